// File: rtl/divider_32_seq.sv
// rtl/divider_32_seq.sv - multi-cycle unsigned restoring divider, one quotient bit per clock
module divider_32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             last_step;

  assign last_step = (count_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      work_q      <= '0;
      dsr_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      work_q      <= work_d;
      dsr_q       <= dsr_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = (divisor == '0) ? S_DONE : S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (last_step) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Full remainder is kept in the shift so divisors above 2^(WIDTH-1) cannot overflow the trial.
  always_comb begin
    count_d     = count_q;
    rem_d       = rem_q;
    work_d      = work_q;
    dsr_d       = dsr_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    shifted     = {rem_q, work_q[WIDTH-1]};
    trial       = shifted - {1'b0, dsr_q};
    if (state_q == S_RUN) begin
      rem_d   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      work_d  = {work_q[WIDTH-2:0], ~trial[WIDTH]};
      count_d = count_q + CW'(1);
      if (last_step) begin
        quotient_d  = work_d;
        remainder_d = rem_d;
      end
    end else if (start) begin
      dsr_d = divisor;
      if (divisor == '0) begin
        quotient_d  = '1;
        remainder_d = dividend;
        dbz_d       = 1'b1;
      end else begin
        rem_d   = '0;
        work_d  = dividend;
        count_d = '0;
        dbz_d   = 1'b0;
      end
    end
  end

  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  assign div_by_zero = dbz_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;

endmodule
